// File: rtl/arisco_pkg.sv
// Shared types and constants for the fetch front end.
package arisco_pkg;

  // Fetch FSM: issue requests, or wait for stale responses after a redirect
  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } fetch_state_t;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush and occupancy count; head is combinational
// from the storage array (registered data, no write-to-read bypass).
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // Pop on empty is ignored; push on full only lands if a pop frees the slot
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush behaves like reset
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps several ROM requests
// in flight, buffers in-order responses in a prefetch queue for decode, and
// handles redirects by flushing the queue and dropping stale responses.
module fetch_unit
  import arisco_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h10,
  parameter int              QUEUE_DEPTH  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  output logic                   o_rom_req_valid,
  input  logic                   i_rom_req_ready,
  output logic [XLEN-1:0]        o_rom_addr,
  input  logic                   i_rom_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_rom_rsp_data,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [XLEN-1:0]        o_instr_pc,
  input  logic                   i_redirect_valid,
  input  logic [XLEN-1:0]        i_redirect_target,
  output logic                   o_misaligned_trap,
  output logic [XLEN-1:0]        o_misaligned_addr
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int QW = INSTR_WIDTH + XLEN;

  fetch_state_t     state, state_nxt;
  logic [XLEN-1:0]  pc, pc_nxt;
  logic [CW-1:0]    outstanding, outstanding_nxt;
  logic [CW-1:0]    discard, discard_nxt;
  logic [CW-1:0]    out_after;

  logic [CW-1:0]    q_count;
  logic             q_full;
  logic             q_empty;
  logic [QW-1:0]    q_head;
  logic             q_push;
  logic             q_pop;

  logic             credit;
  logic             req_fire;
  logic             rsp_fetch;
  logic             misaligned;
  logic [XLEN-1:0]  redirect_pc;
  logic [XLEN-1:0]  rsp_pc;

  // Credit: in-flight requests plus buffered entries never exceed the queue,
  // so every response always has a slot waiting for it.
  assign credit          = ({1'b0, outstanding} + {1'b0, q_count}) < (CW+1)'(QUEUE_DEPTH);
  assign o_rom_req_valid = i_reset_n && (state == S_FETCH) && credit;
  assign o_rom_addr      = pc;
  assign req_fire        = o_rom_req_valid & i_rom_req_ready;
  assign rsp_fetch       = (state == S_FETCH) & i_rom_rsp_valid;
  assign out_after       = outstanding + CW'(req_fire) - CW'(rsp_fetch);

  assign misaligned  = (i_redirect_target[1:0] != 2'b00);
  assign redirect_pc = misaligned ? TRAP_VECTOR : i_redirect_target;

  // Responses return in order and pc is always the next address to issue,
  // so the oldest outstanding request sits PC_STEP*outstanding behind it.
  assign rsp_pc = pc - XLEN'(outstanding) * XLEN'(PC_STEP);

  // A redirect kills the response arriving in the same cycle
  assign q_push        = rsp_fetch & ~i_redirect_valid;
  assign o_instr_valid = i_reset_n & ~q_empty;
  assign q_pop         = o_instr_valid & i_instr_ready;
  assign {o_instr_pc, o_instr} = q_head;

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (QUEUE_DEPTH)
  ) u_prefetch (
    .clk       (i_clk),
    .reset_n   (i_reset_n),
    .push      (q_push),
    .push_data ({rsp_pc, i_rom_rsp_data}),
    .pop       (q_pop),
    .flush     (i_redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Next PC, counters and FSM state
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    case (state)
      S_FETCH: begin
        outstanding_nxt = out_after;
        if (req_fire) pc_nxt = pc + XLEN'(PC_STEP);
        if (i_redirect_valid) begin
          // Everything still in flight (including a request accepted this
          // cycle) becomes stale and must be dropped before fetching again.
          pc_nxt          = redirect_pc;
          outstanding_nxt = '0;
          discard_nxt     = out_after;
          state_nxt       = (out_after != '0) ? S_DRAIN : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (i_rom_rsp_valid) discard_nxt = discard - CW'(1);
        if (i_redirect_valid) pc_nxt = redirect_pc;
        if (discard_nxt == '0) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // FSM, PC and counter registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= S_FETCH;
      pc          <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  // Misaligned-redirect trap: one-cycle pulse, address held until next trap
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_misaligned_trap <= 1'b0;
      o_misaligned_addr <= '0;
    end else begin
      o_misaligned_trap <= i_redirect_valid & misaligned;
      if (i_redirect_valid && misaligned) o_misaligned_addr <= i_redirect_target;
    end
  end

  a_credit: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    ({1'b0, outstanding} + {1'b0, q_count}) <= (CW+1)'(QUEUE_DEPTH));

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(q_push && q_full && !q_pop));

  a_no_stray_rsp: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(rsp_fetch && outstanding == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a ROM model answers accepted requests in
// order after a programmable latency; stimulus pushes expected {pc, instr}
// into a scoreboard and a monitor pops on every decode handshake.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        o_rom_req_valid;
  logic        i_rom_req_ready;
  logic [31:0] o_rom_addr;
  logic        i_rom_rsp_valid;
  logic [31:0] i_rom_rsp_data;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_target;
  logic        o_misaligned_trap;
  logic [31:0] o_misaligned_addr;

  always #5 i_clk = ~i_clk;

  fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .TRAP_VECTOR  (32'h10),
    .QUEUE_DEPTH  (4)
  ) dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .o_rom_req_valid   (o_rom_req_valid),
    .i_rom_req_ready   (i_rom_req_ready),
    .o_rom_addr        (o_rom_addr),
    .i_rom_rsp_valid   (i_rom_rsp_valid),
    .i_rom_rsp_data    (i_rom_rsp_data),
    .o_instr_valid     (o_instr_valid),
    .i_instr_ready     (i_instr_ready),
    .o_instr           (o_instr),
    .o_instr_pc        (o_instr_pc),
    .i_redirect_valid  (i_redirect_valid),
    .i_redirect_target (i_redirect_target),
    .o_misaligned_trap (o_misaligned_trap),
    .o_misaligned_addr (o_misaligned_addr)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } rom_t;

  exp_t        sb[$];
  rom_t        rom_q[$];
  logic [31:0] acc_log[$];
  int          rom_lat = 1;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] rom_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(logic [31:0] pc);
    sb.push_back('{pc, rom_word(pc)});
  endtask

  // ROM: drive responses at negedge, log accepts shortly before posedge
  initial begin
    int t;
    t = 0;
    i_rom_rsp_valid = 1'b0;
    i_rom_rsp_data  = '0;
    forever begin
      @(negedge i_clk);
      t++;
      i_rom_rsp_valid = 1'b0;
      if (rom_q.size() > 0 && rom_q[0].due <= t) begin
        i_rom_rsp_valid = 1'b1;
        i_rom_rsp_data  = rom_word(rom_q[0].addr);
        void'(rom_q.pop_front());
      end
      #3;
      if (!i_reset_n) rom_q.delete();
      else if (o_rom_req_valid && i_rom_req_ready) begin
        rom_q.push_back('{o_rom_addr, t + rom_lat});
        acc_log.push_back(o_rom_addr);
      end
    end
  end

  // Monitor: every decode handshake must match the scoreboard head
  initial begin
    forever begin
      @(negedge i_clk);
      #3;
      if (o_instr_valid && i_instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h, none expected", o_instr_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("instr_pc", o_instr_pc, e.pc);
          check("instr_data", o_instr, e.instr);
        end
      end
    end
  end

  // Raise decode ready until n handshakes happen, then drop it
  task automatic consume(int n);
    int got;
    int budget;
    got = 0;
    budget = 0;
    while (got < n && budget < 200) begin
      @(negedge i_clk);
      i_instr_ready = 1'b1;
      #3;
      if (o_instr_valid) got++;
      budget++;
    end
    @(negedge i_clk);
    i_instr_ready = 1'b0;
    check("consume_count", 32'(got), 32'(n));
  endtask

  // Two reset cycles; returns at the negedge where reset is released
  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n        = 1'b0;
    i_instr_ready    = 1'b0;
    i_redirect_valid = 1'b0;
    i_rom_req_ready  = 1'b1;
    rom_lat          = 1;
    @(negedge i_clk);
    acc_log.delete();
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_reset_n         = 1'b0;
    i_rom_req_ready   = 1'b0;
    i_instr_ready     = 1'b0;
    i_redirect_valid  = 1'b0;
    i_redirect_target = '0;

    // Reset state
    repeat (3) @(negedge i_clk);
    #3;
    check("rst_req_valid", 32'(o_rom_req_valid), 32'd0);
    check("rst_instr_valid", 32'(o_instr_valid), 32'd0);
    check("rst_trap", 32'(o_misaligned_trap), 32'd0);
    check("rst_mis_addr", o_misaligned_addr, 32'h0);

    // 1: stream from reset vector, latency to first instr
    @(negedge i_clk);
    i_reset_n       = 1'b1;
    i_rom_req_ready = 1'b1;
    acc_log.delete();
    #3;
    check("t1_first_req", 32'(o_rom_req_valid), 32'd1);
    check("t1_first_addr", o_rom_addr, 32'h0);
    @(negedge i_clk); #3;
    check("t1_valid_cyc2", 32'(o_instr_valid), 32'd0);
    @(negedge i_clk); #3;
    check("t1_valid_cyc3", 32'(o_instr_valid), 32'd1);
    check("t1_head_pc", o_instr_pc, 32'h0);
    for (int i = 0; i < 8; i++) expect_pc(32'(4 * i));
    consume(8);
    for (int i = 0; i < 8; i++) check("t1_addr_seq", acc_log[i], 32'(4 * i));

    // 2: decode stalled -> queue fills, fetch stops, resumes at 16
    do_reset();
    repeat (10) @(negedge i_clk);
    #3;
    check("t2_accepts", 32'(acc_log.size()), 32'd4);
    check("t2_req_valid", 32'(o_rom_req_valid), 32'd0);
    check("t2_instr_valid", 32'(o_instr_valid), 32'd1);
    for (int i = 0; i < 6; i++) expect_pc(32'(4 * i));
    consume(6);
    check("t2_resume_addr", acc_log[4], 32'h10);

    // 3: three outstanding, redirect to 0x200
    do_reset();
    rom_lat = 4;
    repeat (3) @(negedge i_clk);
    i_rom_req_ready   = 1'b0;
    i_redirect_valid  = 1'b1;
    i_redirect_target = 32'h200;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    i_rom_req_ready  = 1'b1;
    rom_lat          = 1;
    #3;
    check("t3_drain_req_valid", 32'(o_rom_req_valid), 32'd0);
    check("t3_accepts_before", 32'(acc_log.size()), 32'd3);
    expect_pc(32'h200);
    expect_pc(32'h204);
    consume(2);
    check("t3_first_after", acc_log[3], 32'h200);

    // 4: misaligned redirect traps to 0x10
    do_reset();
    @(negedge i_clk);
    i_redirect_valid  = 1'b1;
    i_redirect_target = 32'h202;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    n = acc_log.size();
    #3;
    check("t4_trap_pulse", 32'(o_misaligned_trap), 32'd1);
    check("t4_trap_addr", o_misaligned_addr, 32'h202);
    @(negedge i_clk); #3;
    check("t4_trap_clear", 32'(o_misaligned_trap), 32'd0);
    check("t4_addr_held", o_misaligned_addr, 32'h202);
    expect_pc(32'h10);
    expect_pc(32'h14);
    consume(2);
    check("t4_fetch_trap_vec", acc_log[n], 32'h10);

    // 5: redirect with decode handshake and ROM accept in the same cycle
    do_reset();
    repeat (2) @(negedge i_clk);
    expect_pc(32'h0);
    i_instr_ready     = 1'b1;
    i_redirect_valid  = 1'b1;
    i_redirect_target = 32'h300;
    #3;
    check("t5_head_valid", 32'(o_instr_valid), 32'd1);
    check("t5_req_same_cyc", 32'(o_rom_req_valid), 32'd1);
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    i_instr_ready    = 1'b0;
    #3;
    check("t5_flushed", 32'(o_instr_valid), 32'd0);
    expect_pc(32'h300);
    expect_pc(32'h304);
    consume(2);
    check("t5_first_after", acc_log[3], 32'h300);

    // 6: reset mid-stream, then wrap at top of address space
    do_reset();
    for (int i = 0; i < 3; i++) expect_pc(32'(4 * i));
    consume(3);
    i_reset_n = 1'b0;
    #3;
    check("t6_rst_req_valid", 32'(o_rom_req_valid), 32'd0);
    check("t6_rst_instr_valid", 32'(o_instr_valid), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    acc_log.delete();
    #3;
    check("t6_post_instr_valid", 32'(o_instr_valid), 32'd0);
    check("t6_restart_addr", o_rom_addr, 32'h0);
    expect_pc(32'h0);
    consume(1);

    do_reset();
    i_redirect_valid  = 1'b1;
    i_redirect_target = 32'hFFFF_FFFC;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    consume(2);
    check("t6_wrap_addr", acc_log[2], 32'h0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
